barrett_reduce_pipe: RTL
========================

# barrett_reduce_pipe

Pipelined, parametrised Barrett modular reducer. It computes dout = din mod Q for any din < 2^(2K), where Q is an odd modulus chosen at elaboration time. It has a valid/ready handshake on both sides, full backpressure and a side-band tag carried alongside each sample. It sits between the coefficient multipliers and the NTT/accumulate datapath in the Galois arithmetic units, and replaces the fixed-modulus combinational reducers.

## Interface
Parameters:
- Q, 4049: modulus. Must be odd and 3 ≤ Q < 2^K.
- K, $clog2(Q): modulus bit width. Input width is 2K, output width is K.
- MU, floor(2^(2K)/Q): Barrett constant, derived and never overridden. For Q=4049 it is 4143.
- TAG_W, 4: side-band tag width. Tag is passed through unchanged.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- flush, input, 1: synchronous clear of all in-flight samples.
- in_valid, input, 1: din/in_tag are valid.
- in_ready, output, 1: block accepts a sample this cycle.
- din, input, 2K: value to reduce, unsigned.
- in_tag, input, TAG_W: tag accompanying din.
- out_valid, output, 1: dout/out_tag are valid.
- out_ready, input, 1: downstream accepts a sample.
- dout, output, K: din mod Q, always in [0, Q-1].
- out_tag, output, TAG_W: tag of the sample on dout.
- busy, output, 1: OR of all stage valid bits.

## Operation
- Four registered stages, each holding a valid bit, its data and its tag.
- S1 captures a = din and q1 = a >> (K-1).
- S2 computes q2 = q1 * MU, at full product width (K+2 + K+1 bits, no truncation).
- S3 computes q3 = q2 >> (K+1), then r = a - q3*Q in 2K+1 bits. The result is guaranteed to lie in [0, 3Q).
- S4 applies two cascaded conditional subtractions: r ≥ Q then r -= Q, twice. It registers the low K bits as dout.
- Global advance enable: en = !out_valid || out_ready.
  - When en=1, every stage loads from its predecessor. S1 loads in_valid && in_ready.
  - When en=0, all stages hold.
- in_ready = en. This is combinational from out_ready and out_valid.
- A sample transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- Stalls never drop or duplicate samples. Order is strictly preserved, and the tag always stays with its data.
- flush=1 clears all four valid bits at the next edge. Data registers are don't-care. While flush=1, in_ready=0 and any input offered in that cycle is not accepted. flush overrides en.
- Bubbles are allowed: a stage with valid=0 advances like any other. The pipeline does not compact bubbles while stalled.
- Data and tag registers update only when en=1, so outputs are stable while out_valid && !out_ready.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits go to 0 → out_valid=0, busy=0, in_ready=1 once released. dout=0 and out_tag=0 are also reset.
- Latency is 4 cycles with no backpressure. A sample accepted at edge n appears with out_valid=1 after edge n+3, and is consumable at edge n+4.
- Throughput is 1 sample/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and the whole pipeline freezes.
- Reset asserted mid-stream discards all in-flight samples immediately. No partial output is ever seen.
- Simultaneous flush and in_valid: the input is not accepted, and the pipeline is empty next cycle.
- Simultaneous output transfer and input acceptance in the same cycle is allowed (full-rate streaming).
- Boundary inputs 0, Q-1, Q, 2^(2K)-1 must all produce exact results. No overflow is permitted at any intermediate width.

## Test plan
- Reset/idle (Q=4049): release rst_n with in_valid=0 → out_valid=0, busy=0, in_ready=1, dout=0.
- Directed values, streamed back-to-back with out_ready=1 and tags 0..5:
  - din 0 → 0
  - din 4048 → 4048
  - din 4049 → 0
  - din 8097 → 4048
  - din 16386304 (4048²) → 1
  - din 16777215 → 2208
  - Each result appears exactly 4 cycles after acceptance, with its matching tag.
- Backpressure: stream 20 random samples while toggling out_ready with a pseudo-random pattern → every output matches din mod 4049, in order, with no loss or duplicates. dout is stable while stalled, and in_ready mirrors en.
- Flush: accept 3 samples, assert flush for one cycle while in_valid=1 → no outputs ever appear from those samples, busy=0 on the next cycle, and the offered input is not accepted.
- Async reset mid-stream: assert rst_n low between clock edges with 4 samples in flight → out_valid drops to 0 immediately, and after release the first new sample returns correctly after 4 cycles.
- Parameter sweep: instantiate with Q=3329 (K=12) and Q=17 (K=5), drive exhaustive or 10k random din < 2^(2K) → dout equals din mod Q in every case.

Source files
------------

// File: rtl/barrett_reduce_pipe_if.sv
// Streaming handshake bundle for barrett_reduce_pipe: input sample/tag in, reduced sample/tag out.
// master is the environment side and slave is the reducer side.
interface barrett_reduce_pipe_if #(
   parameter int unsigned K     = 12,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2*K-1:0]   din;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [K-1:0]     dout;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, din, in_tag, out_ready,
      input  in_ready, out_valid, dout, out_tag
   );

   modport slave (
      input  in_valid, din, in_tag, out_ready,
      output in_ready, out_valid, dout, out_tag
   );
endinterface

// File: rtl/barrett_reduce_pipe.sv
// Four-stage pipelined Barrett reducer: dout = din mod Q for din < 2^(2K).
// A single global advance enable freezes every stage under backpressure.
module barrett_reduce_pipe #(
   parameter int unsigned Q     = 4049,
   parameter int unsigned K     = $clog2(Q),
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   barrett_reduce_pipe_if.slave bus,
   output logic                 busy
);
   localparam int unsigned AW  = 2 * K;
   localparam int unsigned Q1W = K + 1;
   localparam int unsigned MUW = K + 1;
   localparam int unsigned PW  = 2 * K + 3;
   localparam int unsigned Q3W = PW - (K + 1);
   localparam int unsigned QPW = Q3W + K;
   localparam int unsigned RW  = 2 * K + 1;

   // floor(2^(2K)/Q) always fits in K+1 bits because Q >= 2^(K-1)
   localparam logic [MUW-1:0] MU = MUW'((64'd1 << AW) / 64'(Q));
   localparam logic [K-1:0]   QK = K'(Q);

   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
   logic [AW-1:0]    a1_q, a1_d, a2_q, a2_d;
   logic [Q1W-1:0]   q1_q, q1_d;
   logic [PW-1:0]    q2_q, q2_d;
   logic [RW-1:0]    r3_q, r3_d;
   logic [K-1:0]     dout_q, dout_d;
   logic [TAG_W-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, t4_q, t4_d;

   logic             en_c;
   logic             accept_c;
   logic [Q3W-1:0]   q3;
   logic [QPW-1:0]   qp;
   logic [RW-1:0]    r_new, r_a, r_b;

   assign en_c         = !v4_q || bus.out_ready;
   assign bus.in_ready = en_c && !flush;
   assign accept_c     = bus.in_valid && bus.in_ready;

   assign bus.out_valid = v4_q;
   assign bus.dout      = dout_q;
   assign bus.out_tag   = t4_q;
   assign busy          = v1_q || v2_q || v3_q || v4_q;

   // Next-state for all stages; data/tag only move when the pipe advances
   always_comb begin
      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;
      v4_d   = v4_q;
      a1_d   = a1_q;
      a2_d   = a2_q;
      q1_d   = q1_q;
      q2_d   = q2_q;
      r3_d   = r3_q;
      dout_d = dout_q;
      t1_d   = t1_q;
      t2_d   = t2_q;
      t3_d   = t3_q;
      t4_d   = t4_q;

      q3    = Q3W'(q2_q >> (K + 1));
      qp    = QPW'(q3) * QPW'(QK);
      // q3*Q never exceeds a, so the difference is non-negative and below 3Q
      r_new = RW'({1'b0, a2_q}) - RW'(qp);
      r_a   = (r3_q >= RW'(QK)) ? (r3_q - RW'(QK)) : r3_q;
      r_b   = (r_a  >= RW'(QK)) ? (r_a  - RW'(QK)) : r_a;

      if (en_c) begin
         v1_d   = accept_c;
         a1_d   = bus.din;
         q1_d   = Q1W'(bus.din >> (K - 1));
         t1_d   = bus.in_tag;
         v2_d   = v1_q;
         a2_d   = a1_q;
         q2_d   = PW'(q1_q) * PW'(MU);
         t2_d   = t1_q;
         v3_d   = v2_q;
         r3_d   = r_new;
         t3_d   = t2_q;
         v4_d   = v3_q;
         dout_d = K'(r_b);
         t4_d   = t3_q;
      end

      if (flush) begin
         v1_d = 1'b0;
         v2_d = 1'b0;
         v3_d = 1'b0;
         v4_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         v4_q   <= 1'b0;
         a1_q   <= '0;
         a2_q   <= '0;
         q1_q   <= '0;
         q2_q   <= '0;
         r3_q   <= '0;
         dout_q <= '0;
         t1_q   <= '0;
         t2_q   <= '0;
         t3_q   <= '0;
         t4_q   <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         v4_q   <= v4_d;
         a1_q   <= a1_d;
         a2_q   <= a2_d;
         q1_q   <= q1_d;
         q2_q   <= q2_d;
         r3_q   <= r3_d;
         dout_q <= dout_d;
         t1_q   <= t1_d;
         t2_q   <= t2_d;
         t3_q   <= t3_d;
         t4_q   <= t4_d;
      end
   end
endmodule
